dsp_mode_bits_loader: RTL and testbench
=======================================

# dsp_mode_bits_loader

Serial configuration loader for the RS_DSP multiplier-accumulator. It receives a serial stream of mode bits, assembles the 84-bit MODE_BITS word in a staging shift register, and commits it atomically to a shadow register. The shadow register drives the DSP mode fields: four 20-bit coefficients, output select and input-register enable. It sits between the fabric configuration controller and the DSP macro, and is the run-time counterpart of the static MODE_BITS packing in the DSP techmap.

## Interface
- MODE_WIDTH, 84: width of MODE_BITS; fixed as 4×20 + 3 + 1.
- RESET_MODE, 84'd0: shadow register value after reset.

- clock_i  in  1  single clock; everything is sampled on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- cfg_start_i  in  1  begin a load; sampled in any state.
- cfg_valid_i  in  1  cfg_bit_i is valid this cycle.
- cfg_bit_i  in  1  serial mode bit; MODE_BITS index 0 first (COEFF_0 MSB first).
- cfg_ready_o  out  1  loader accepts a bit this cycle.
- cfg_busy_o  out  1  load in progress.
- cfg_done_o  out  1  one-cycle pulse on commit.
- cfg_error_o  out  1  sticky error; cleared by the next cfg_start_i.
- mode_bits_o  out  [0:83]  committed shadow word.
- coeff_0_o, coeff_1_o, coeff_2_o, coeff_3_o  out  [0:19] each  mode_bits_o[0:19], [20:39], [40:59], [60:79].
- output_select_o  out  [0:2]  mode_bits_o[80:82].
- register_inputs_o  out  1  mode_bits_o[83].

## Operation
- States: IDLE, SHIFT, CHECK (only with the macro), COMMIT.
- IDLE:
  - cfg_ready_o = 0.
  - cfg_start_i → SHIFT, bit counter = 0, cfg_error_o cleared.
- SHIFT:
  - cfg_ready_o = 1.
  - Each cycle with cfg_valid_i = 1 writes staging[count] = cfg_bit_i and increments count.
  - When the bit at count 83 is accepted: go to CHECK with the macro, otherwise to COMMIT.
  - cfg_valid_i = 0 stalls without timeout.
- CHECK:
  - cfg_ready_o = 1 and one more bit is accepted: the even-parity bit.
  - XOR of staging[0:83] with the parity bit = 0 → COMMIT.
  - Otherwise → IDLE with cfg_error_o = 1; the shadow register is unchanged.
- COMMIT:
  - cfg_ready_o = 0.
  - shadow ← staging and cfg_done_o = 1 for this cycle, then → IDLE.
- cfg_start_i in SHIFT or CHECK aborts the current load and restarts it: count = 0, staging contents are don't-care, the shadow register is untouched.
- cfg_start_i in COMMIT: the commit completes, then the loader goes to SHIFT instead of IDLE.
- Start takes priority over a bit in the same cycle. That bit is dropped, and cfg_ready_o is 0 on any cycle where cfg_start_i = 1.
- cfg_valid_i in IDLE or COMMIT is ignored.
- Decoded outputs are pure slices of the shadow register and never show partial loads.

## Timing
- Reset values:
  - state IDLE, count 0, cfg_ready_o 0, cfg_busy_o 0, cfg_done_o 0, cfg_error_o 0.
  - staging 0; shadow and mode_bits_o = RESET_MODE, with all decoded fields following from it.
- cfg_busy_o = 1 in SHIFT, CHECK and COMMIT.
- cfg_ready_o is combinational from state and cfg_start_i only; it does not depend on cfg_valid_i.
- Minimum load without the macro:
  - start at cycle 0; bits accepted at cycles 1–84; COMMIT at cycle 85.
  - cfg_done_o and the new mode_bits_o are visible after edge 85; back in IDLE at cycle 86.
- With the macro, everything after the 84th bit shifts by one cycle: the parity bit is accepted at cycle 85 and COMMIT is at cycle 86.
- Reset asserted mid-load returns to the reset values asynchronously. The shadow register goes to RESET_MODE, not the previous value.

## Configuration
- DSP_CFG_PARITY_EN defined:
  - The CHECK state exists.
  - Each load is 85 bits, with one trailing even-parity bit.
  - A mismatch sets cfg_error_o and blocks the commit.
- Not defined:
  - No CHECK state and no parity bit.
  - cfg_error_o is tied to 0.
  - A load is exactly 84 bits.

## Test plan
- Reset then idle → mode_bits_o = 84'd0, all control outputs 0, cfg_ready_o 0 while idle.
- Start plus 84 back-to-back bits encoding COEFF_0 = 20'hABCDE, COEFF_3 = 20'h00001, OUTPUT_SELECT = 3'b101, REGISTER_INPUTS = 1 → cfg_done_o pulses at cycle 85 and each decoded field matches.
- Same load with random cfg_valid_i gaps (about 50% duty) → identical result; mode_bits_o holds its old value until the done cycle.
- Restart after 40 bits with a new start, then a full load of all-ones → mode_bits_o = all ones, exactly one cfg_done_o pulse.
- reset_i low at bit 60 of a load, following a previous commit of pattern P → outputs return to reset values immediately; P is not retained.
- With DSP_CFG_PARITY_EN:
  - correct parity → commit;
  - flipped parity bit → cfg_error_o = 1, no cfg_done_o, shadow unchanged;
  - the next cfg_start_i clears cfg_error_o.

Source files
------------

// File: rtl/dsp_mode_bits_loader.sv
// Serial MODE_BITS loader for the RS_DSP MAC: shifts 84 bits into a staging register and commits them atomically.
// Optional feature: define DSP_CFG_PARITY_EN to require a trailing even-parity bit before commit.
module dsp_mode_bits_loader #(
    parameter int                      MODE_WIDTH = 84,
    parameter logic [0:MODE_WIDTH-1]   RESET_MODE = '0
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    cfg_start_i,
    input  logic                    cfg_valid_i,
    input  logic                    cfg_bit_i,
    output logic                    cfg_ready_o,
    output logic                    cfg_busy_o,
    output logic                    cfg_done_o,
    output logic                    cfg_error_o,
    output logic [0:MODE_WIDTH-1]   mode_bits_o,
    output logic [0:19]             coeff_0_o,
    output logic [0:19]             coeff_1_o,
    output logic [0:19]             coeff_2_o,
    output logic [0:19]             coeff_3_o,
    output logic [0:2]              output_select_o,
    output logic                    register_inputs_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
`ifdef DSP_CFG_PARITY_EN
        S_CHECK,
`endif
        S_COMMIT
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [6:0]              r_count;
    logic [0:MODE_WIDTH-1]   r_staging;
    logic [0:MODE_WIDTH-1]   r_shadow;
    logic                    r_done;
    logic                    w_accept;
    logic                    w_lastBit;
    logic                    w_shiftAccept;

    // A start request always wins, so the loader never advertises readiness on a start cycle.
`ifdef DSP_CFG_PARITY_EN
    assign cfg_ready_o = ((r_state == S_SHIFT) || (r_state == S_CHECK)) && !cfg_start_i;
`else
    assign cfg_ready_o = (r_state == S_SHIFT) && !cfg_start_i;
`endif

    assign w_accept      = cfg_ready_o && cfg_valid_i;
    assign w_shiftAccept = w_accept && (r_state == S_SHIFT);
    assign w_lastBit     = (r_count == 7'(MODE_WIDTH - 1));

`ifdef DSP_CFG_PARITY_EN
    logic w_parityFail;
    logic r_error;
`endif

    always_comb begin
        w_nextState = r_state;
`ifdef DSP_CFG_PARITY_EN
        w_parityFail = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (cfg_start_i) w_nextState = S_SHIFT;
            end
            S_SHIFT: begin
                if (cfg_start_i) begin
                    w_nextState = S_SHIFT;
                end else if (cfg_valid_i && w_lastBit) begin
`ifdef DSP_CFG_PARITY_EN
                    w_nextState = S_CHECK;
`else
                    w_nextState = S_COMMIT;
`endif
                end
            end
`ifdef DSP_CFG_PARITY_EN
            S_CHECK: begin
                if (cfg_start_i) begin
                    w_nextState = S_SHIFT;
                end else if (cfg_valid_i) begin
                    if ((^r_staging) ^ cfg_bit_i) begin
                        w_nextState  = S_IDLE;
                        w_parityFail = 1'b1;
                    end else begin
                        w_nextState = S_COMMIT;
                    end
                end
            end
`endif
            S_COMMIT: begin
                w_nextState = cfg_start_i ? S_SHIFT : S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_staging <= '0;
            r_shadow  <= RESET_MODE;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (cfg_start_i) begin
                r_count <= '0;
            end else if (w_shiftAccept) begin
                r_count <= r_count + 7'd1;
            end
            if (w_shiftAccept) begin
                r_staging[r_count] <= cfg_bit_i;
            end
            if (r_state == S_COMMIT) begin
                r_shadow <= r_staging;
            end
            r_done <= (r_state == S_COMMIT);
        end
    end

`ifdef DSP_CFG_PARITY_EN
    // Error is sticky until the next start request, regardless of state.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_error <= 1'b0;
        end else if (cfg_start_i) begin
            r_error <= 1'b0;
        end else if (w_parityFail) begin
            r_error <= 1'b1;
        end
    end
    assign cfg_error_o = r_error;
`else
    assign cfg_error_o = 1'b0;
`endif

    assign cfg_busy_o        = (r_state != S_IDLE);
    assign cfg_done_o        = r_done;
    assign mode_bits_o       = r_shadow;
    assign coeff_0_o         = r_shadow[0:19];
    assign coeff_1_o         = r_shadow[20:39];
    assign coeff_2_o         = r_shadow[40:59];
    assign coeff_3_o         = r_shadow[60:79];
    assign output_select_o   = r_shadow[80:82];
    assign register_inputs_o = r_shadow[83];

endmodule

// File: tb/tb_dsp_mode_bits_loader.sv
// Scoreboard bench for dsp_mode_bits_loader: randomized serial loads against a field-level reference model.
// Also exercises the DSP_CFG_PARITY_EN build when that macro is defined.
module tb_dsp_mode_bits_loader;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          cfg_start_i;
    logic          cfg_valid_i;
    logic          cfg_bit_i;
    logic          cfg_ready_o;
    logic          cfg_busy_o;
    logic          cfg_done_o;
    logic          cfg_error_o;
    logic [0:83]   mode_bits_o;
    logic [0:19]   coeff_0_o;
    logic [0:19]   coeff_1_o;
    logic [0:19]   coeff_2_o;
    logic [0:19]   coeff_3_o;
    logic [0:2]    output_select_o;
    logic          register_inputs_o;

    dsp_mode_bits_loader dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .cfg_start_i       (cfg_start_i),
        .cfg_valid_i       (cfg_valid_i),
        .cfg_bit_i         (cfg_bit_i),
        .cfg_ready_o       (cfg_ready_o),
        .cfg_busy_o        (cfg_busy_o),
        .cfg_done_o        (cfg_done_o),
        .cfg_error_o       (cfg_error_o),
        .mode_bits_o       (mode_bits_o),
        .coeff_0_o         (coeff_0_o),
        .coeff_1_o         (coeff_1_o),
        .coeff_2_o         (coeff_2_o),
        .coeff_3_o         (coeff_3_o),
        .output_select_o   (output_select_o),
        .register_inputs_o (register_inputs_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [83:0] word;
        int          doneCycle;
    } exp_t;

    exp_t        expQ[$];
    logic [83:0] curShadow;
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;

`ifdef DSP_CFG_PARITY_EN
    localparam int LOAD_BITS = 85;
`else
    localparam int LOAD_BITS = 84;
`endif

    always @(posedge clock_i) cycle++;

    // Field-level model: COEFF_0 occupies the most significant end and goes out first.
    function automatic logic [83:0] packMode(input logic [19:0] c0, input logic [19:0] c1,
                                             input logic [19:0] c2, input logic [19:0] c3,
                                             input logic [2:0] os, input logic ri);
        return {c0, c1, c2, c3, os, ri};
    endfunction

    function automatic logic [83:0] randWord();
        return packMode(20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
                        3'($urandom), 1'($urandom));
    endfunction

    task automatic checkOutput(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest expected commit; otherwise the shadow must hold.
    always @(negedge clock_i) begin
        exp_t e;
        if (reset_i === 1'b1) begin
            if (cfg_done_o) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cycle);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("commit_word", mode_bits_o, e.word);
                    checkOutput("done_cycle", 84'(cycle), 84'(e.doneCycle));
                    checkOutput("coeff_0", 84'(coeff_0_o), 84'(e.word[83:64]));
                    checkOutput("coeff_1", 84'(coeff_1_o), 84'(e.word[63:44]));
                    checkOutput("coeff_2", 84'(coeff_2_o), 84'(e.word[43:24]));
                    checkOutput("coeff_3", 84'(coeff_3_o), 84'(e.word[23:4]));
                    checkOutput("output_select", 84'(output_select_o), 84'(e.word[3:1]));
                    checkOutput("register_inputs", 84'(register_inputs_o), 84'(e.word[0]));
                    curShadow = e.word;
                end
            end else begin
                checkOutput("shadow_hold", mode_bits_o, curShadow);
            end
        end
    end

    // One load: start, then bits with random gaps; abortAt stops early, badParity corrupts the parity bit.
    task automatic applyStimulus(input logic [83:0] w, input int gapPct, input int abortAt,
                                 input bit badParity);
        int i;
        cfg_start_i = 1'b1;
        cfg_valid_i = 1'($urandom);
        cfg_bit_i   = 1'($urandom);
        #1 checkOutput("ready_low_on_start", 84'(cfg_ready_o), 84'(0));
        tick();
        cfg_start_i = 1'b0;
        i = 0;
        while (i < LOAD_BITS) begin
            if (i == abortAt) begin
                cfg_valid_i = 1'b0;
                return;
            end
            cfg_valid_i = ($urandom_range(99) >= gapPct);
            if (!cfg_valid_i)     cfg_bit_i = 1'($urandom);
            else if (i < 84)      cfg_bit_i = w[83 - i];
            else                  cfg_bit_i = (^w) ^ badParity;
            #1 checkOutput("ready_in_load", 84'(cfg_ready_o), 84'(1));
            checkOutput("busy_in_load", 84'(cfg_busy_o), 84'(1));
            if (cfg_valid_i && i == LOAD_BITS - 1 && !badParity)
                expQ.push_back('{w, cycle + 2});
            tick();
            if (cfg_valid_i) i++;
        end
        cfg_valid_i = 1'b0;
    endtask

    task automatic applyReset();
        @(posedge clock_i);
        #2 reset_i = 1'b0;
        #1;
        checkOutput("async_reset_mode", mode_bits_o, 84'd0);
        checkOutput("async_reset_busy", 84'(cfg_busy_o), 84'(0));
        checkOutput("async_reset_ready", 84'(cfg_ready_o), 84'(0));
        checkOutput("async_reset_done", 84'(cfg_done_o), 84'(0));
        checkOutput("async_reset_error", 84'(cfg_error_o), 84'(0));
        curShadow = '0;
        expQ.delete();
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [83:0] w;
        logic [83:0] p;
        reset_i     = 1'b0;
        cfg_start_i = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_bit_i   = 1'b0;
        curShadow   = '0;
        #12;
        checkOutput("reset_mode", mode_bits_o, 84'd0);
        checkOutput("reset_ready", 84'(cfg_ready_o), 84'(0));
        checkOutput("reset_busy", 84'(cfg_busy_o), 84'(0));
        checkOutput("reset_done", 84'(cfg_done_o), 84'(0));
        checkOutput("reset_error", 84'(cfg_error_o), 84'(0));
        @(negedge clock_i);
        reset_i = 1'b1;
        tick();

        // Idle with stray valid bits must stay idle.
        for (int k = 0; k < 6; k++) begin
            cfg_valid_i = 1'($urandom);
            cfg_bit_i   = 1'($urandom);
            #1 checkOutput("idle_ready", 84'(cfg_ready_o), 84'(0));
            checkOutput("idle_busy", 84'(cfg_busy_o), 84'(0));
            tick();
        end
        cfg_valid_i = 1'b0;

        // Directed back-to-back load, then the same load with gaps.
        w = packMode(20'hABCDE, 20'($urandom), 20'($urandom), 20'h00001, 3'b101, 1'b1);
        applyStimulus(w, 0, -1, 1'b0);
        repeat (3) tick();
        applyStimulus(randWord(), 50, -1, 1'b0);
        repeat (2) tick();
        applyStimulus(w, 50, -1, 1'b0);
        repeat (3) tick();

        // Restart after 40 bits, then all ones.
        applyStimulus(randWord(), 0, 40, 1'b0);
        applyStimulus({84{1'b1}}, 30, -1, 1'b0);
        repeat (3) tick();

        // Chained loads: each new start lands in the commit cycle of the previous one.
        for (int k = 0; k < 4; k++) applyStimulus(randWord(), $urandom_range(60), -1, 1'b0);
        repeat (3) tick();

        // Reset in the middle of a load after committing pattern P.
        p = randWord();
        applyStimulus(p, 20, -1, 1'b0);
        repeat (3) tick();
        applyStimulus(randWord(), 0, 60, 1'b0);
        applyReset();
        repeat (2) tick();
        applyStimulus(randWord(), 40, -1, 1'b0);
        repeat (3) tick();

`ifdef DSP_CFG_PARITY_EN
        applyStimulus(randWord(), 30, -1, 1'b0);
        repeat (3) tick();
        applyStimulus(randWord(), 30, -1, 1'b1);
        checkOutput("parity_error_set", 84'(cfg_error_o), 84'(1));
        checkOutput("parity_error_idle", 84'(cfg_busy_o), 84'(0));
        repeat (3) tick();
        checkOutput("parity_error_sticky", 84'(cfg_error_o), 84'(1));
        cfg_start_i = 1'b1;
        tick();
        cfg_start_i = 1'b0;
        checkOutput("parity_error_cleared", 84'(cfg_error_o), 84'(0));
        applyStimulus(randWord(), 30, -1, 1'b0);
        repeat (3) tick();
`else
        checkOutput("error_tied_low", 84'(cfg_error_o), 84'(0));
`endif

        repeat (4) tick();
        checkOutput("queue_drained", 84'(expQ.size()), 84'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
